// File: rtl/inst_loader_pkg.sv
// -----------------------------------------------------------------------------
// inst_loader_pkg
// Shared definitions for the instruction-memory loader:
//   - loader_state_t : loader FSM states
//   - INST_W         : instruction word width (32)
//   - BYTES_PER_WORD : stream bytes per instruction word (4)
//   - DEFAULT_ADDR_W : default word-address width (5 -> 32 words)
// No ports (package).
// -----------------------------------------------------------------------------
package inst_loader_pkg;

  localparam int INST_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int DEFAULT_ADDR_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    CHECK,
    DONE
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Packs a byte stream into big-endian instruction words. The first byte of a
// word ends up in [31:24], the fourth in [7:0].
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   clear     in   restart packing at byte 0 (start of a new load)
//   shift_en  in   a byte is being accepted this cycle
//   byte_in   in   [7:0] stream byte
//   word      out  [INST_W-1:0] assembled word, valid while word_full is high
//   word_full out  this cycle's byte completes a word
// -----------------------------------------------------------------------------
module byte_packer
  import inst_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [INST_W-1:0] word,
  output logic              word_full
);

  localparam int         HELD_W    = INST_W - 8;
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [HELD_W-1:0] held;
  logic [1:0]        byte_cnt;

  // Only the first three bytes are stored; the fourth is taken straight from
  // the input so the full word is available in the same cycle it completes,
  // letting the write strobe follow the last byte by exactly one cycle.
  assign word      = {held, byte_in};
  assign word_full = shift_en && (byte_cnt == LAST_BYTE);

  // Shift in accepted bytes and count position within the word. The 2-bit
  // counter wraps naturally after the fourth byte, ready for the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held     <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      held     <= '0;
      byte_cnt <= '0;
    end else if (shift_en) begin
      held     <= {held[HELD_W-9:0], byte_in};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
// Loads a program into the CPU instruction memory from a byte stream. Bytes
// arrive on a valid/ready handshake, are packed big-endian into 32-bit words
// and written at word addresses 0,1,2,... while the CPU is held stalled.
//
// Optional feature macro: INSTLOAD_CHECKSUM_EN
//   defined   : one trailing XOR checksum byte is consumed after the last
//               word and a mismatch sets the sticky Err flag
//   undefined : no checksum byte is consumed, Err is tied low
//
// Parameters:
//   ADDR_W     word-address width, memory depth 2^ADDR_W words
// Ports:
//   Clk        in   clock, rising edge
//   Rst_n      in   asynchronous active-low reset
//   Load       in   start pulse, sampled only when idle
//   Len        in   [ADDR_W:0] words to load, clamped to 2^ADDR_W
//   ByteIn     in   [7:0] stream data
//   ByteValid  in   ByteIn valid
//   ByteReady  out  loader accepts a byte this cycle
//   WrEn       out  instruction-memory write strobe
//   WrAddr     out  [ADDR_W-1:0] word address
//   WrData     out  [31:0] assembled instruction word
//   CpuHold    out  CPU stall, from Load acceptance through Done
//   Done       out  one-cycle completion pulse
//   Err        out  sticky checksum error
// -----------------------------------------------------------------------------
module inst_mem_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Load,
  input  logic [ADDR_W:0]   Len,
  input  logic [7:0]        ByteIn,
  input  logic              ByteValid,
  output logic              ByteReady,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [INST_W-1:0] WrData,
  output logic              CpuHold,
  output logic              Done,
  output logic              Err
);

  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_WORD  = {{ADDR_W{1'b0}}, 1'b1};

  loader_state_t     state;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   word_cnt;
  logic [ADDR_W:0]   word_cnt_next;
  logic [ADDR_W:0]   len_clamped;
  logic              accept;
  logic              start;
  logic              pack_shift;
  logic              word_full;
  logic [INST_W-1:0] packed_word;

  assign accept        = ByteValid && ByteReady;
  assign start         = (state == IDLE) && Load;
  assign pack_shift    = accept && (state == COLLECT);
  assign word_cnt_next = word_cnt + ONE_WORD;

  // Clamping at capture keeps the word counter from ever passing the top
  // address, so WrAddr cannot wrap inside one load.
  assign len_clamped = (Len > MAX_WORDS) ? MAX_WORDS : Len;

  byte_packer u_packer (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .clear     (start),
    .shift_en  (pack_shift),
    .byte_in   (ByteIn),
    .word      (packed_word),
    .word_full (word_full)
  );

  // Loader FSM. Every output is registered and updated on the same edge as
  // the state change, so ByteReady is high exactly in COLLECT/CHECK, WrEn
  // exactly in WRITE and Done exactly in DONE.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      word_cnt  <= '0;
      ByteReady <= 1'b0;
      WrEn      <= 1'b0;
      WrAddr    <= '0;
      WrData    <= '0;
      CpuHold   <= 1'b0;
      Done      <= 1'b0;
    end else begin
      WrEn <= 1'b0;
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Load) begin
            len_q    <= len_clamped;
            word_cnt <= '0;
            CpuHold  <= 1'b1;
            if (len_clamped == '0) begin
`ifdef INSTLOAD_CHECKSUM_EN
              state     <= CHECK;
              ByteReady <= 1'b1;
`else
              state <= DONE;
              Done  <= 1'b1;
`endif
            end else begin
              state     <= COLLECT;
              ByteReady <= 1'b1;
            end
          end
        end

        COLLECT: begin
          if (word_full) begin
            state     <= WRITE;
            ByteReady <= 1'b0;
            WrEn      <= 1'b1;
            WrAddr    <= word_cnt[ADDR_W-1:0];
            WrData    <= packed_word;
          end
        end

        WRITE: begin
          word_cnt <= word_cnt_next;
          if (word_cnt_next == len_q) begin
`ifdef INSTLOAD_CHECKSUM_EN
            state     <= CHECK;
            ByteReady <= 1'b1;
`else
            state <= DONE;
            Done  <= 1'b1;
`endif
          end else begin
            state     <= COLLECT;
            ByteReady <= 1'b1;
          end
        end

`ifdef INSTLOAD_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            state     <= DONE;
            ByteReady <= 1'b0;
            Done      <= 1'b1;
          end
        end
`endif

        DONE: begin
          state   <= IDLE;
          CpuHold <= 1'b0;
        end

        default: begin
          state     <= IDLE;
          ByteReady <= 1'b0;
          CpuHold   <= 1'b0;
        end
      endcase
    end
  end

`ifdef INSTLOAD_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR over data bytes only; the checksum byte itself is compared
  // against it in CHECK. Err is sticky until the next accepted Load.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      csum <= '0;
      Err  <= 1'b0;
    end else if (start) begin
      csum <= '0;
      Err  <= 1'b0;
    end else begin
      if (pack_shift) begin
        csum <= csum ^ ByteIn;
      end
      if (accept && (state == CHECK) && (ByteIn != csum)) begin
        Err <= 1'b1;
      end
    end
  end
`else
  assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_mem_loader
// Self-checking bench for inst_mem_loader. A negedge monitor logs every write,
// handshake and Done pulse; each load is compared against a reference built
// directly from the byte stream (big-endian words at addresses 0..n-1, XOR
// checksum). Follows INSTLOAD_CHECKSUM_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_inst_mem_loader;

  localparam int AW = 5;

`ifdef INSTLOAD_CHECKSUM_EN
  localparam int CSUM_BYTES = 1;
`else
  localparam int CSUM_BYTES = 0;
`endif

  typedef logic [AW+31:0] wr_t;

  typedef struct {
    logic [AW:0] len;
    int          idle_hi;
    int          exp_words;
    logic [7:0]  flip;
  } vec_t;

  logic          Clk;
  logic          Rst_n;
  logic          Load;
  logic [AW:0]   Len;
  logic [7:0]    ByteIn;
  logic          ByteValid;
  logic          ByteReady;
  logic          WrEn;
  logic [AW-1:0] WrAddr;
  logic [31:0]   WrData;
  logic          CpuHold;
  logic          Done;
  logic          Err;

  int vec_cnt = 0;
  int miscompares = 0;

  // monitor-owned counters
  wr_t wr_log[$];
  int  acc_cnt = 0;
  int  done_cnt = 0;
  int  hold_low = 0;
  int  early_write = 0;

  // driver-owned state
  logic [7:0] stream[$];
  logic [7:0] prog_a[8];
  logic [7:0] prog_b[4];
  vec_t       vecs[10];
  int  acc_base = 0;
  int  wr_base = 0;
  int  done_base = 0;
  int  hold_base = 0;
  int  early_base = 0;
  int  stall_to = 0;
  bit  hold_window = 0;

  inst_mem_loader #(.ADDR_W(AW)) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Load      (Load),
    .Len       (Len),
    .ByteIn    (ByteIn),
    .ByteValid (ByteValid),
    .ByteReady (ByteReady),
    .WrEn      (WrEn),
    .WrAddr    (WrAddr),
    .WrData    (WrData),
    .CpuHold   (CpuHold),
    .Done      (Done),
    .Err       (Err)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Observes the DUT mid-cycle. A write is legal only once all four bytes of
  // that word have been handed over.
  always @(negedge Clk) begin
    if (WrEn) begin
      if ((acc_cnt - acc_base) != 4 * (wr_log.size() - wr_base + 1)) early_write++;
      wr_log.push_back({WrAddr, WrData});
    end
    if (ByteValid && ByteReady) acc_cnt++;
    if (Done) done_cnt++;
    if (hold_window && !CpuHold) hold_low++;
  end

  function automatic logic [31:0] model_word(input int i);
    return {stream[4*i], stream[4*i+1], stream[4*i+2], stream[4*i+3]};
  endfunction

  function automatic logic [7:0] model_csum(input int nbytes);
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < nbytes; k++) x = x ^ stream[k];
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vec_cnt++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic fill_random(input int nbytes);
    stream.delete();
    for (int k = 0; k < nbytes; k++) stream.push_back(8'($urandom));
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte has transferred.
  task automatic send_byte(input logic [7:0] b, input int idle);
    bit ok;
    ByteValid = 1'b0;
    repeat (idle) begin
      @(posedge Clk);
      #1;
    end
    ByteIn    = b;
    ByteValid = 1'b1;
    ok = 1'b0;
    for (int g = 0; g < 50 && !ok; g++) begin
      @(negedge Clk);
      if (ByteReady) ok = 1'b1;
      @(posedge Clk);
      #1;
    end
    if (!ok) stall_to++;
    ByteValid = 1'b0;
  endtask

  task automatic start_load(input logic [AW:0] len);
    acc_base   = acc_cnt;
    wr_base    = wr_log.size();
    done_base  = done_cnt;
    hold_base  = hold_low;
    early_base = early_write;
    Load = 1'b1;
    Len  = len;
    @(posedge Clk);
    #1;
    Load = 1'b0;
    // scramble Len: the captured value must be the one in use
    Len  = (AW+1)'($urandom);
    hold_window = 1'b1;
  endtask

  // Waits for Done, then keeps offering a byte to prove nothing more is taken.
  task automatic finish_load(output bit got_done);
    got_done = 1'b0;
    for (int g = 0; g < 40 && !got_done; g++) begin
      @(negedge Clk);
      if (Done) got_done = 1'b1;
    end
    hold_window = 1'b0;
    ByteIn    = 8'hA5;
    ByteValid = 1'b1;
    repeat (4) @(negedge Clk);
    ByteValid = 1'b0;
  endtask

  task automatic checkLoad(input string tag, input int n_words, input bit err_exp,
                           input bit got_done);
    int  n_got;
    wr_t w;
    n_got = wr_log.size() - wr_base;
    checkOutput({tag, " done seen"}, 64'(got_done), 64'd1);
    checkOutput({tag, " write count"}, 64'(n_got), 64'(n_words));
    for (int i = 0; i < n_got && i < n_words; i++) begin
      w = wr_log[wr_base + i];
      checkOutput({tag, " addr"}, 64'(w[AW+31:32]), 64'(i));
      checkOutput({tag, " data"}, 64'(w[31:0]), 64'(model_word(i)));
    end
    checkOutput({tag, " done pulses"}, 64'(done_cnt - done_base), 64'd1);
    checkOutput({tag, " hold gaps"}, 64'(hold_low - hold_base), 64'd0);
    checkOutput({tag, " early writes"}, 64'(early_write - early_base), 64'd0);
    checkOutput({tag, " bytes taken"}, 64'(acc_cnt - acc_base),
                64'(4 * n_words + CSUM_BYTES));
    checkOutput({tag, " hold released"}, 64'(CpuHold), 64'd0);
    checkOutput({tag, " err"}, 64'(Err), 64'(err_exp));
    checkOutput({tag, " stalls"}, 64'(stall_to), 64'd0);
  endtask

  task automatic applyStimulus(input string tag, input logic [AW:0] len,
                               input int n_words, input int idle_lo,
                               input int idle_hi, input logic [7:0] flip);
    bit got;
    bit err_exp;
    err_exp = (CSUM_BYTES == 1) && (flip != 8'h00);
    start_load(len);
    for (int k = 0; k < 4 * n_words; k++)
      send_byte(stream[k], int'($urandom_range(idle_hi, idle_lo)));
    if (CSUM_BYTES == 1)
      send_byte(model_csum(4 * n_words) ^ flip, int'($urandom_range(idle_hi, idle_lo)));
    finish_load(got);
    checkLoad(tag, n_words, err_exp, got);
  endtask

  initial begin
    bit  got;
    wr_t w;

    prog_a = '{8'h20, 8'h01, 8'h00, 8'h08, 8'h34, 8'h02, 8'h00, 8'h0C};
    prog_b = '{8'h00, 8'h22, 8'h18, 8'h20};

    // len, idle_hi, expected words, checksum corruption
    vecs[0] = '{6'd2,  0, 2,  8'h00};
    vecs[1] = '{6'd1,  2, 1,  8'h00};
    vecs[2] = '{6'd5,  3, 5,  8'h00};
    vecs[3] = '{6'd0,  0, 0,  8'h00};
    vecs[4] = '{6'd32, 0, 32, 8'h00};
    vecs[5] = '{6'd40, 1, 32, 8'h00};
    vecs[6] = '{6'd63, 0, 32, 8'h00};
    vecs[7] = '{6'd7,  4, 7,  8'h40};
    vecs[8] = '{6'd3,  0, 3,  8'h00};
    vecs[9] = '{6'd31, 1, 31, 8'h81};

    Rst_n = 1'b1;
    Load = 1'b0;
    Len = '0;
    ByteIn = 8'h00;
    ByteValid = 1'b0;
    #1 Rst_n = 1'b0;

    @(negedge Clk);
    checkOutput("reset ByteReady", 64'(ByteReady), 64'd0);
    checkOutput("reset WrEn", 64'(WrEn), 64'd0);
    checkOutput("reset WrAddr", 64'(WrAddr), 64'd0);
    checkOutput("reset WrData", 64'(WrData), 64'd0);
    checkOutput("reset CpuHold", 64'(CpuHold), 64'd0);
    checkOutput("reset Done", 64'(Done), 64'd0);
    checkOutput("reset Err", 64'(Err), 64'd0);
    @(posedge Clk);
    #1 Rst_n = 1'b1;
    @(posedge Clk);
    #1;

    // Known two-word program, back-to-back bytes.
    stream.delete();
    foreach (prog_a[k]) stream.push_back(prog_a[k]);
    start_load(6'd2);
    checkOutput("ready after load", 64'(ByteReady), 64'd1);
    checkOutput("hold after load", 64'(CpuHold), 64'd1);
    for (int k = 0; k < 8; k++) send_byte(stream[k], 0);
    if (CSUM_BYTES == 1) send_byte(model_csum(8), 0);
    finish_load(got);
    checkLoad("prog", 2, 1'b0, got);
    if (wr_log.size() >= wr_base + 2) begin
      w = wr_log[wr_base];
      checkOutput("prog word0", 64'(w[31:0]), 64'h20010008);
      w = wr_log[wr_base + 1];
      checkOutput("prog word1", 64'(w[31:0]), 64'h3402000C);
    end

    // Same program with three idle cycles before every byte.
    applyStimulus("prog idle3", 6'd2, 2, 3, 3, 8'h00);
    if (wr_log.size() >= wr_base + 2) begin
      w = wr_log[wr_base + 1];
      checkOutput("prog idle3 word1", 64'(w[31:0]), 64'h3402000C);
    end

`ifdef INSTLOAD_CHECKSUM_EN
    // 00^22^18^20 = 1A
    stream.delete();
    foreach (prog_b[k]) stream.push_back(prog_b[k]);
    applyStimulus("csum good", 6'd1, 1, 0, 0, 8'h00);
    applyStimulus("csum bad", 6'd1, 1, 0, 0, 8'h01);
    checkOutput("csum bad sticky", 64'(Err), 64'd1);
`else
    // Zero-length load: Done in the cycle right after the sampling edge,
    // i.e. the second cycle counting the Load cycle itself.
    start_load(6'd0);
    @(negedge Clk);
    checkOutput("len0 done", 64'(Done), 64'd1);
    checkOutput("len0 hold", 64'(CpuHold), 64'd1);
    checkOutput("len0 ready", 64'(ByteReady), 64'd0);
    @(negedge Clk);
    hold_window = 1'b0;
    checkOutput("len0 done width", 64'(Done), 64'd0);
    checkOutput("len0 hold drop", 64'(CpuHold), 64'd0);
    checkOutput("len0 writes", 64'(wr_log.size() - wr_base), 64'd0);
`endif

    // Table of randomized loads.
    for (int v = 0; v < 10; v++) begin
      fill_random(4 * vecs[v].exp_words);
      applyStimulus($sformatf("vec%0d", v), vecs[v].len, vecs[v].exp_words,
                    0, vecs[v].idle_hi, vecs[v].flip);
    end

    // Load pulsed mid-collect must be ignored.
    fill_random(8);
    start_load(6'd2);
    send_byte(stream[0], 0);
    send_byte(stream[1], 1);
    Load = 1'b1;
    Len  = 6'd5;
    @(posedge Clk);
    #1;
    Load = 1'b0;
    for (int k = 2; k < 8; k++) send_byte(stream[k], 0);
    if (CSUM_BYTES == 1) send_byte(model_csum(8), 0);
    finish_load(got);
    checkLoad("load ignored", 2, 1'b0, got);

    // Reset in the middle of a four-word load.
    fill_random(16);
    start_load(6'd4);
    for (int k = 0; k < 10; k++) send_byte(stream[k], 0);
    hold_window = 1'b0;
    Rst_n = 1'b0;
    #1;
    checkOutput("abort outputs", 64'({ByteReady, WrEn, WrAddr, WrData, CpuHold, Done, Err}),
                64'd0);
    checkOutput("abort writes kept", 64'(wr_log.size() - wr_base), 64'd2);
    checkOutput("abort stalls", 64'(stall_to), 64'd0);
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
    repeat (3) @(negedge Clk);
    checkOutput("abort no done", 64'(done_cnt - done_base), 64'd0);
    @(posedge Clk);
    #1;
    fill_random(8);
    applyStimulus("after abort", 6'd2, 2, 0, 1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
